vacc_readout: RTL and testbench
===============================

VACC_READOUT -- requirements
Module: vacc_readout

Interface
REQ-001 SHALL have parameter VECTOR_WIDTH, default 11, log2 of words per spectrum frame (N = 2^VECTOR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, width of each accumulated word.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_data  input  DATA_WIDTH  accumulated word from the upstream accumulator.
REQ-006 wr_en  input  1  write strobe for wr_data.
REQ-007 wr_addr  input  VECTOR_WIDTH  word index of wr_data.
REQ-008 m_data  output  DATA_WIDTH  stream data.
REQ-009 m_valid  output  1  stream data valid.
REQ-010 m_ready  input  1  downstream accepts the beat.
REQ-011 m_last  output  1  final beat of a frame.
REQ-012 overflow  output  1  one-cycle pulse when a completed frame is dropped.
REQ-013 frames_dropped  output  16  saturating count of dropped frames.
REQ-014 busy  output  1  high while a frame is queued or streaming.

Function
REQ-015 SHALL hold two banks of N x DATA_WIDTH words (ping-pong); one bank is the write bank, the other the read bank.
REQ-016 When wr_en=1, SHALL store wr_data at wr_addr in the write bank that cycle.
REQ-017 Frame completion SHALL be the first cycle with wr_en=0 after one or more cycles with wr_en=1.
REQ-018 On completion with reader idle, SHALL swap banks and start streaming the just-written bank the next cycle.
REQ-019 On completion with reader busy, SHALL not swap, SHALL pulse overflow for one cycle, SHALL increment frames_dropped (saturate at 65535); the write bank is then reused.
REQ-020 Completion in the same cycle as acceptance of the last beat (m_valid & m_ready & m_last) SHALL count as reader idle (no overflow).
REQ-021 Reader states: IDLE, PRIME (bank read issued, 1-cycle RAM latency), STREAM; IDLE->PRIME on start, PRIME->STREAM when first word registered, STREAM->IDLE on last-beat acceptance.
REQ-022 SHALL stream words in address order 0..N-1, exactly N beats per frame (plus header per REQ-033); m_last high only on beat N-1.
REQ-023 First m_valid SHALL assert no later than 3 cycles after the completion cycle.
REQ-024 m_valid SHALL not depend combinationally on m_ready; while m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-025 With m_ready held high, SHALL sustain one beat per cycle with no bubbles within a frame.
REQ-026 Words not written during the frame SHALL stream the bank's stale contents; no zero-fill.
REQ-027 busy SHALL be high from the completion cycle through last-beat acceptance.
REQ-028 m_data SHALL be 0 whenever m_valid=0.

Reset
REQ-029 On rst: m_valid=0, m_last=0, m_data=0, overflow=0, frames_dropped=0, busy=0, reader IDLE, write bank=bank 0, completion detector cleared.
REQ-030 rst mid-stream SHALL abort the frame; m_valid=0 the cycle after rst is sampled; no partial frame resumes.
REQ-031 Bank RAM contents SHALL not be cleared by rst.

Configuration
REQ-032 Macro VACC_READOUT_HEADER_EN SHALL select a frame header.
REQ-033 With VACC_READOUT_HEADER_EN defined: each frame SHALL be prefixed by one header beat, m_data = {32-bit frame sequence number (starts 0 after reset, +1 per streamed frame, wraps), 16-bit frames_dropped, zero fill}; frame is N+1 beats; REQ-023 applies to the header beat.
REQ-034 Without VACC_READOUT_HEADER_EN: no header, N beats per frame, no sequence counter logic.

Verification
REQ-035 VECTOR_WIDTH=4; write addr 0..15 data=addr+100, drop wr_en, m_ready=1 -> 16 beats 100..115 consecutive, m_last on 115, first m_valid <=3 cycles after wr_en fall.
REQ-036 Same frame, m_ready toggling 1/0 each cycle -> identical sequence, m_data stable on every stalled cycle, no duplicates or skips.
REQ-037 Second frame completes while first streaming with m_ready=0 -> overflow pulse 1 cycle, frames_dropped=1, first frame resumes intact when m_ready=1.
REQ-038 Second completion coincident with last-beat acceptance -> no overflow, second frame streams next.
REQ-039 rst asserted at beat 7 -> m_valid=0 next cycle, frames_dropped=0, next full frame streams from word 0.
REQ-040 With VACC_READOUT_HEADER_EN: two frames -> 17 beats each, headers carry sequence 0 then 1, frames_dropped field 0.

Source files
------------

// File: rtl/vacc_readout_if.sv
// Accumulator write port plus the ready/valid output stream of vacc_readout.
// master = the readout block (stream source); slave = accumulator/consumer side.
interface vacc_readout_if #(
  parameter int VECTOR_WIDTH = 11,
  parameter int DATA_WIDTH   = 128
);
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_en;
  logic [VECTOR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]   m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;

  modport master (
    input  wr_data, wr_en, wr_addr, m_ready,
    output m_data, m_valid, m_last
  );
  modport slave (
    output wr_data, wr_en, wr_addr, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/vacc_readout.sv
// Ping-pong frame buffer: captures accumulator frames and streams them out word 0..N-1.
// VACC_READOUT_HEADER_EN adds a {seq, frames_dropped} header beat ahead of each frame.
module vacc_readout #(
  parameter int VECTOR_WIDTH = 11,
  parameter int DATA_WIDTH   = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  vacc_readout_if.master        bus,
  output logic                  overflow,
  output logic [15:0]           frames_dropped,
  output logic                  busy
);
  localparam int N = 1 << VECTOR_WIDTH;
  localparam logic [VECTOR_WIDTH-1:0] LAST_ADDR = VECTOR_WIDTH'(N - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t                  state_q, state_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic                    wr_seen_q, wr_seen_d;
  logic [VECTOR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
`ifdef VACC_READOUT_HEADER_EN
  logic [31:0]             seq_q, seq_d;
  logic [DATA_WIDTH-1:0]   hdr_word;
`endif

  // Bank storage is deliberately outside the reset domain.
  logic [DATA_WIDTH-1:0] bank_mem [2*N];

  always_ff @(posedge clk) begin
    if (bus.wr_en) bank_mem[{wr_bank_q, bus.wr_addr}] <= bus.wr_data;
  end

  logic                  complete;
  logic                  beat_acc;
  logic                  last_acc;
  logic                  rd_idle;
  logic [DATA_WIDTH-1:0] rd_word;

  assign complete = wr_seen_q & ~bus.wr_en;
  assign beat_acc = m_valid_q & bus.m_ready;
  assign last_acc = beat_acc & m_last_q;
  // A frame finishing its last beat this cycle frees the reader for a new completion.
  assign rd_idle  = (state_q == IDLE) | last_acc;
  assign rd_word  = bank_mem[{rd_bank_q, rd_addr_q}];
`ifdef VACC_READOUT_HEADER_EN
  assign hdr_word = {seq_q, drop_cnt_q, {(DATA_WIDTH-48){1'b0}}};
`endif

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_seen_d  = bus.wr_en;
    rd_addr_d  = rd_addr_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    overflow_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
`ifdef VACC_READOUT_HEADER_EN
    seq_d      = seq_q;
`endif

    if (complete) begin
      if (rd_idle) begin
        wr_bank_d = ~wr_bank_q;
        rd_bank_d = wr_bank_q;
      end else begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (complete) begin
          state_d   = PRIME;
          rd_addr_d = '0;
        end
      end
      PRIME: begin
        state_d   = STREAM;
        m_valid_d = 1'b1;
`ifdef VACC_READOUT_HEADER_EN
        m_data_d  = hdr_word;
        m_last_d  = 1'b0;
        seq_d     = seq_q + 32'd1;
`else
        m_data_d  = rd_word;
        m_last_d  = (rd_addr_q == LAST_ADDR);
        rd_addr_d = rd_addr_q + VECTOR_WIDTH'(1);
`endif
      end
      STREAM: begin
        if (beat_acc) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_last_d  = 1'b0;
            rd_addr_d = '0;
            state_d   = complete ? PRIME : IDLE;
          end else begin
            m_data_d  = rd_word;
            m_last_d  = (rd_addr_q == LAST_ADDR);
            rd_addr_d = rd_addr_q + VECTOR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      rd_addr_q  <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
`ifdef VACC_READOUT_HEADER_EN
      seq_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_seen_q  <= wr_seen_d;
      rd_addr_q  <= rd_addr_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef VACC_READOUT_HEADER_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign overflow       = overflow_q;
  assign frames_dropped = drop_cnt_q;
  assign busy           = (state_q != IDLE) | complete;
endmodule

// File: tb/tb_vacc_readout.sv
// Randomised bench for vacc_readout with a frame-level reference model and directed scenarios.
module tb_vacc_readout;
  localparam int VW = 4;
  localparam int DW = 128;
  localparam int N  = 16;
`ifdef VACC_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vacc_readout_if #(.VECTOR_WIDTH(VW), .DATA_WIDTH(DW)) bus ();
  logic        overflow;
  logic [15:0] frames_dropped;
  logic        busy;

  vacc_readout #(.VECTOR_WIDTH(VW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .overflow       (overflow),
    .frames_dropped (frames_dropped),
    .busy           (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: bank images, queue of expected output beats, drop/sequence counters.
  typedef struct {
    logic [DW-1:0] dat;
    bit            last;
    bit            first;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] mbank [2][N];
  logic [DW-1:0] acc_log[$];
  int            mwb = 0;
  bit            prev_wr = 0;
  int            mdrops = 0;
  int unsigned   mseq = 0;
  bit            ovf_exp = 0;
  bit            rst_prev = 0;
  bit            prev_hs_nonlast = 0;
  int            lat = 0;
  int            ovf_cnt = 0;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mbank[b][i] = '0;
  end

  always @(negedge clk) begin
    bit comp, idle, hs;
    if (rst) begin
      q.delete();
      mwb = 0; prev_wr = 0; mdrops = 0; mseq = 0;
      ovf_exp = 0; rst_prev = 1; prev_hs_nonlast = 0; lat = 0;
    end else begin
      if (rst_prev) check("valid_after_rst", bus.m_valid, 0);
      rst_prev = 0;
      comp = prev_wr && !bus.wr_en;
      hs   = bus.m_valid && bus.m_ready;
      check("overflow", overflow, ovf_exp);
      check("frames_dropped", frames_dropped, mdrops);
      check("busy", busy, (q.size() > 0) || comp);
      if (overflow) ovf_cnt++;
      if (prev_hs_nonlast) check("no_bubble", bus.m_valid, 1);
      if (q.size() > 0 && q[0].first) begin
        if (bus.m_valid) check("first_valid_latency_le3", lat <= 2, 1);
        else lat++;
      end
      if (bus.m_valid) begin
        if (q.size() == 0) check("valid_without_frame", bus.m_valid, 0);
        else begin
          check("m_data", bus.m_data, q[0].dat);
          check("m_last", bus.m_last, q[0].last);
        end
      end else begin
        check("data_zero_when_idle", bus.m_data, 0);
      end
      idle = (q.size() == 0) || (hs && q.size() == 1 && q[0].last);
      prev_hs_nonlast = hs && !bus.m_last;
      if (hs && q.size() > 0) begin
        acc_log.push_back(bus.m_data);
        void'(q.pop_front());
      end
      ovf_exp = 0;
      if (comp) begin
        if (idle) begin
          if (HDR != 0) begin
            q.push_back('{dat: {mseq[31:0], 16'(mdrops), 80'b0}, last: 1'b0, first: 1'b1});
            mseq++;
          end
          for (int i = 0; i < N; i++)
            q.push_back('{dat: mbank[mwb][i], last: (i == N-1), first: (i == 0 && HDR == 0)});
          mwb ^= 1;
          lat = 0;
        end else begin
          ovf_exp = 1;
          if (mdrops < 65535) mdrops++;
        end
      end
      if (bus.wr_en) mbank[mwb][bus.wr_addr] = bus.wr_data;
      prev_wr = bus.wr_en;
    end
  end

  // m_ready driver: 0 high, 1 toggle, 2 random, 3 low, 4 follow man_ready.
  int rmode = 0;
  bit man_ready = 1'b0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: bus.m_ready = 1'b1;
        1: bus.m_ready = ~bus.m_ready;
        2: bus.m_ready = 1'($urandom_range(0, 1));
        3: bus.m_ready = 1'b0;
        default: bus.m_ready = man_ready;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_words(input int base);
    for (int i = 0; i < N; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = VW'(i); bus.wr_data = DW'(base + i);
      tick();
    end
  endtask

  task automatic write_seq(input int base);
    write_words(base);
    bus.wr_en = 1'b0;
    tick();
  endtask

  task automatic write_rand(input int nw);
    for (int k = 0; k < nw; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = VW'($urandom_range(0, N-1));
      bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || bus.m_valid) && n < 3000) begin tick(); n++; end
    check(name, n < 3000, 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.m_valid && n < 50) begin tick(); n++; end
    check(name, n < 50, 1);
  endtask

  task automatic check_frame(input string name, input int base, input int off);
    for (int i = 0; i < N; i++) check(name, acc_log[off + HDR + i], DW'(base + i));
  endtask

  initial begin
    int n;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frames_dropped", frames_dropped, 0);
    check("rst_busy", busy, 0);
    tick();

    // Sequential frame at full rate
    acc_log.delete(); rmode = 0;
    write_seq(100);
    wait_idle("f1_done");
    check("f1_beats", acc_log.size(), N + HDR);
    check_frame("f1_data", 100, 0);
`ifdef VACC_READOUT_HEADER_EN
    check("f1_hdr_seq", acc_log[0][127:96], 0);
    check("f1_hdr_drops", acc_log[0][95:80], 0);
`endif

    // Same frame with m_ready toggling
    acc_log.delete(); rmode = 1;
    write_seq(100);
    wait_idle("f2_done");
    check("f2_beats", acc_log.size(), N + HDR);
    check_frame("f2_data", 100, 0);
`ifdef VACC_READOUT_HEADER_EN
    check("f2_hdr_seq", acc_log[0][127:96], 1);
    check("f2_hdr_drops", acc_log[0][95:80], 0);
`endif

    // Second frame completes while the first is stalled
    acc_log.delete(); ovf_cnt = 0; rmode = 3;
    write_seq(200);
    wait_valid("ovf_first_valid");
    write_seq(300);
    repeat (3) tick();
    check("ovf_pulses", ovf_cnt, 1);
    check("ovf_frames_dropped", frames_dropped, 1);
    rmode = 0;
    wait_idle("ovf_done");
    check("ovf_beats", acc_log.size(), N + HDR);
    check_frame("ovf_first_intact", 200, 0);

    // Completion coincident with last-beat acceptance
    acc_log.delete(); ovf_cnt = 0; man_ready = 1'b0; rmode = 4;
    write_seq(400);
    wait_valid("coin_first_valid");
    write_words(500);
    man_ready = 1'b1;
    n = 0;
    while (!(bus.m_valid && bus.m_last && bus.m_ready) && n < 100) begin
      bus.wr_en = 1'b1; bus.wr_addr = VW'(N-1); bus.wr_data = DW'(500 + N - 1);
      tick(); n++;
    end
    check("coin_reached_last", n < 100, 1);
    bus.wr_en = 1'b0;
    tick();
    rmode = 0;
    wait_idle("coin_done");
    check("coin_no_overflow", ovf_cnt, 0);
    check("coin_beats", acc_log.size(), 2 * (N + HDR));
    check_frame("coin_frame1", 400, 0);
    check_frame("coin_frame2", 500, N + HDR);

    // Reset in the middle of a frame
    acc_log.delete(); rmode = 0;
    write_seq(600);
    n = 0;
    while (acc_log.size() < 7 + HDR && n < 50) begin tick(); n++; end
    check("mid_rst_reached_beat7", n < 50, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", bus.m_valid, 0);
    check("mid_rst_frames_dropped", frames_dropped, 0);
    tick();
    acc_log.delete();
    write_seq(700);
    wait_idle("post_rst_done");
    check("post_rst_beats", acc_log.size(), N + HDR);
    check_frame("post_rst_data", 700, 0);
`ifdef VACC_READOUT_HEADER_EN
    check("post_rst_hdr_seq", acc_log[0][127:96], 0);
`endif

    // Random partial frames, random gaps and random backpressure
    rmode = 2;
    for (int it = 0; it < 24; it++) begin
      write_rand($urandom_range(1, 20));
      repeat ($urandom_range(0, 25)) tick();
    end
    wait_idle("rand_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
